// File: rtl/ps2_host_tx_if.sv
// Data-bus port of the PS/2 host transmitter: one 16-bit register at $FFFE.
interface ps2_host_tx_if;
  logic [15:0] dat_dat_i;
  logic [15:0] dat_dat_o;
  logic        dat_we_i;
  logic        dat_cyc_i;
  logic        dat_stb_i;
  logic        dat_ack_o;

  modport master (
    output dat_dat_i, dat_we_i, dat_cyc_i, dat_stb_i,
    input  dat_dat_o, dat_ack_o
  );

  modport slave (
    input  dat_dat_i, dat_we_i, dat_cyc_i, dat_stb_i,
    output dat_dat_o, dat_ack_o
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with a single status/command register.
// A CPU write in IDLE launches inhibit -> request-to-send -> 11-edge frame;
// reads report {busy, nack, timeout, overrun, 4'b0, last byte}.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned START_TIMEOUT  = 375000,
  parameter int unsigned FRAME_TIMEOUT  = 50000
) (
  input  logic         sys_clk_i,
  input  logic         sys_rst_i,
  ps2_host_tx_if.slave bus,
  input  logic         ps2c_i,
  input  logic         ps2d_i,
  output logic         ps2c_oe_o,
  output logic         ps2d_oe_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INHIBIT  = 3'd1;
  localparam logic [2:0] REQ      = 3'd2;
  localparam logic [2:0] WAIT_CLK = 3'd3;
  localparam logic [2:0] SHIFT    = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;
  localparam logic [2:0] DRAIN    = 3'd6;
  localparam logic [2:0] ERR_TO   = 3'd7;

  localparam logic [18:0] INH_LAST   = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] START_LAST = 19'(START_TIMEOUT - 1);
  localparam logic [18:0] FRAME_LAST = 19'(FRAME_TIMEOUT - 1);

  logic [2:0]  state;
  logic [18:0] timer;
  logic [18:0] timer_inc;
  logic [3:0]  bitcount;
  logic [7:0]  data;
  logic        par;
  logic        err_nack;
  logic        err_timeout;
  logic        overrun;
  logic        ack;
  logic        drain_seen;
  logic        c_s1, c_sync, c_prev;
  logic        d_s1, d_sync;
  logic        fall;
  logic        wr;
  logic        busy;
  logic        unused_hi;

  assign fall      = c_prev & ~c_sync;
  assign wr        = bus.dat_cyc_i & bus.dat_stb_i & bus.dat_we_i & ~ack;
  assign busy      = (state != IDLE);
  assign unused_hi = ^bus.dat_dat_i[15:8];

  assign bus.dat_ack_o = ack;
  assign bus.dat_dat_o = {busy, err_nack, err_timeout, overrun, 4'b0000, data};

  // Saturating increment shared by the inhibit, start and frame timers.
  always_comb begin
    timer_inc = (timer == '1) ? timer : timer + 19'd1;
  end

  // Two-flop synchronizers on both lines plus a delayed copy of the clock for edge detection.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      c_s1   <= 1'b1;
      c_sync <= 1'b1;
      c_prev <= 1'b1;
      d_s1   <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_s1   <= ps2c_i;
      c_sync <= c_s1;
      c_prev <= c_sync;
      d_s1   <= ps2d_i;
      d_sync <= d_s1;
    end
  end

  // Bus acknowledge, command latch and the host-to-device frame sequencer.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state       <= IDLE;
      timer       <= '0;
      bitcount    <= '0;
      data        <= '0;
      par         <= 1'b0;
      err_nack    <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
      ack         <= 1'b0;
      drain_seen  <= 1'b0;
      ps2c_oe_o   <= 1'b0;
      ps2d_oe_o   <= 1'b0;
    end else begin
      ack <= bus.dat_cyc_i & bus.dat_stb_i & ~ack;
      if (wr && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          ps2c_oe_o <= 1'b0;
          ps2d_oe_o <= 1'b0;
          if (wr) begin
            data        <= bus.dat_dat_i[7:0];
            par         <= ~^bus.dat_dat_i[7:0];
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            timer       <= '0;
            ps2c_oe_o   <= 1'b1;
            state       <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer >= INH_LAST) begin
            ps2d_oe_o <= 1'b1;
            state     <= REQ;
          end else begin
            timer <= timer_inc;
          end
        end
        REQ: begin
          ps2c_oe_o <= 1'b0;
          timer     <= '0;
          state     <= WAIT_CLK;
        end
        WAIT_CLK: begin
          if (fall) begin
            ps2d_oe_o <= ~data[0];
            bitcount  <= 4'd1;
            timer     <= '0;
            state     <= SHIFT;
          end else if (timer >= START_LAST) begin
            ps2c_oe_o   <= 1'b0;
            ps2d_oe_o   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= ERR_TO;
          end else begin
            timer <= timer_inc;
          end
        end
        SHIFT: begin
          timer <= timer_inc;
          if (fall) begin
            bitcount <= bitcount + 4'd1;
            if (bitcount < 4'd8) begin
              ps2d_oe_o <= ~data[bitcount[2:0]];
            end else if (bitcount == 4'd8) begin
              ps2d_oe_o <= ~par;
            end else begin
              ps2d_oe_o <= 1'b0;
              state     <= ACK;
            end
          end else if (timer >= FRAME_LAST) begin
            ps2c_oe_o   <= 1'b0;
            ps2d_oe_o   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= ERR_TO;
          end
        end
        ACK: begin
          timer <= timer_inc;
          if (fall) begin
            err_nack   <= d_sync;
            bitcount   <= 4'd11;
            drain_seen <= 1'b0;
            state      <= DRAIN;
          end else if (timer >= FRAME_LAST) begin
            err_timeout <= 1'b1;
            state       <= ERR_TO;
          end
        end
        DRAIN: begin
          timer <= timer_inc;
          if (c_sync && d_sync && drain_seen) begin
            state <= IDLE;
          end else if (timer >= FRAME_LAST) begin
            err_timeout <= 1'b1;
            state       <= ERR_TO;
          end else begin
            drain_seen <= c_sync & d_sync;
          end
        end
        ERR_TO: begin
          ps2c_oe_o <= 1'b0;
          ps2d_oe_o <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model drives the lines,
// a timestamp-based model predicts line drives and status every cycle.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 16;
  localparam int S   = 200;
  localparam int F   = 600;
  localparam int H   = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_c = 1'b1;
  logic dev_d = 1'b1;
  logic ps2c_i, ps2d_i, ps2c_oe_o, ps2d_oe_o;

  ps2_host_tx_if bus_if ();

  assign ps2c_i = ~ps2c_oe_o & dev_c;
  assign ps2d_i = ~ps2d_oe_o & dev_d;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (S),
    .FRAME_TIMEOUT (F)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .bus      (bus_if),
    .ps2c_i   (ps2c_i),
    .ps2d_i   (ps2d_i),
    .ps2c_oe_o(ps2c_oe_o),
    .ps2d_oe_o(ps2d_oe_o)
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Frame record: edge indices at which the host reacts to each event.
  bit          have = 0;
  int          fw;
  logic [7:0]  fbyte;
  int          rx [1:11];
  int          nf;
  int          drain_done;
  int          ovr_edge;
  bit          nack_frame;
  logic [15:0] prev_status = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Expected {c_oe, d_oe, status} after posedge n, derived from the frame timeline.
  function automatic logic [17:0] model(input int n);
    int r, t_to, e_end, k;
    bit to_hit, busy, nack, ovr;
    logic c, d, par;
    if (!have || n < fw) return {2'b00, prev_status};
    r   = fw + INH + 1;
    par = ~^fbyte;
    if (nf == 0 || rx[1] > r + S) begin
      t_to   = r + S;
      to_hit = (n >= t_to);
    end else begin
      t_to   = rx[1] + F;
      to_hit = (n >= t_to) && (drain_done == 0 || drain_done > t_to);
    end
    if (to_hit)              e_end = t_to + 1;
    else if (drain_done != 0) e_end = drain_done;
    else                     e_end = 32'h7fffffff;
    busy = (n < e_end);
    if (n < fw + INH)       begin c = 1; d = 0; end
    else if (n == fw + INH) begin c = 1; d = 1; end
    else if (to_hit)        begin c = 0; d = 0; end
    else if (nf == 0 || n < rx[1]) begin c = 0; d = 1; end
    else begin
      k = 0;
      for (int i = 1; i <= 10; i++) if (i <= nf && rx[i] <= n) k++;
      c = 0;
      if (k <= 8)      d = ~fbyte[k-1];
      else if (k == 9) d = ~par;
      else             d = 0;
    end
    nack = nack_frame && nf >= 11 && n >= rx[11];
    ovr  = (ovr_edge != 0) && (n >= ovr_edge);
    return {c, d, busy, nack, to_hit, ovr, 4'b0000, fbyte};
  endfunction

  // Every cycle outside reset, lines and status must follow the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (chk_en)
        check("cycle", {14'b0, ps2c_oe_o, ps2d_oe_o, bus_if.dat_dat_o}, {14'b0, model(ecount)});
    end
  end

  task automatic bus_write(input logic [15:0] v);
    logic [17:0] m;
    @(negedge clk);
    m = model(ecount);
    if (m[15]) begin
      if (ovr_edge == 0) ovr_edge = ecount + 1;
    end else begin
      prev_status = m[15:0];
      have = 1; fw = ecount + 1; fbyte = v[7:0]; nf = 0;
      for (int i = 1; i <= 11; i++) rx[i] = 0;
      drain_done = 0; ovr_edge = 0; nack_frame = 0;
    end
    bus_if.dat_dat_i = v;
    bus_if.dat_we_i  = 1'b1;
    bus_if.dat_cyc_i = 1'b1;
    bus_if.dat_stb_i = 1'b1;
    @(negedge clk);
    check("wr_ack", bus_if.dat_ack_o, 1);
    bus_if.dat_cyc_i = 1'b0;
    bus_if.dat_stb_i = 1'b0;
    bus_if.dat_we_i  = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", bus_if.dat_ack_o, 0);
  endtask

  task automatic bus_read(output logic [15:0] v);
    @(negedge clk);
    bus_if.dat_we_i  = 1'b0;
    bus_if.dat_cyc_i = 1'b1;
    bus_if.dat_stb_i = 1'b1;
    @(negedge clk);
    check("rd_ack", bus_if.dat_ack_o, 1);
    v = bus_if.dat_dat_o;
    bus_if.dat_cyc_i = 1'b0;
    bus_if.dat_stb_i = 1'b0;
    @(negedge clk);
  endtask

  // Device: waits for request-to-send, then clocks up to stop_after edges.
  task automatic dev_frame(input int stop_after, input bit ack_low,
                           output logic [10:0] samp, output int rts_at);
    int guard;
    samp = '0;
    guard = 0;
    while (!(ps2c_oe_o == 1'b0 && ps2d_oe_o == 1'b1) && guard < INH + 40) begin
      @(negedge clk);
      guard++;
    end
    rts_at = ecount;
    check("rts_seen", (guard < INH + 40), 1);
    if (guard >= INH + 40) return;
    repeat (5) @(negedge clk);
    samp[0] = ps2d_i;
    nack_frame = !ack_low;
    for (int i = 1; i <= 11; i++) begin
      if (i > stop_after) break;
      @(negedge clk);
      if (i == 11 && ack_low) dev_d = 1'b0;
      dev_c = 1'b0;
      rx[i] = ecount + 3;
      nf = i;
      repeat (H) @(negedge clk);
      dev_c = 1'b1;
      if (i <= 10) samp[i] = ps2d_i;
      if (i == 11) begin
        dev_d = 1'b1;
        drain_done = ecount + 4;
      end
      repeat (H - 1) @(negedge clk);
    end
  endtask

  task automatic wait_status_bit(input int b, input logic val, input string name);
    int guard;
    guard = 0;
    while (bus_if.dat_dat_o[b] !== val && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(name, (guard < 2000), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [10:0] samp;
    int rts;

    bus_if.dat_dat_i = '0;
    bus_if.dat_we_i  = 1'b0;
    bus_if.dat_cyc_i = 1'b0;
    bus_if.dat_stb_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;

    bus_read(v);
    check("reset_status", v, 16'h0000);

    // $ED: odd parity 1, ACKed
    bus_write(16'h00ED);
    dev_frame(11, 1, samp, rts);
    check("inhibit_len", rts - fw, INH + 1);
    check("bits_ed", samp, 11'h7DA);
    wait_status_bit(15, 1'b0, "idle_ed");
    bus_read(v);
    check("status_ed", v, 16'h00ED);

    bus_write(16'h0001);
    dev_frame(11, 1, samp, rts);
    check("bits_01", samp, 11'h402);
    wait_status_bit(15, 1'b0, "idle_01");
    bus_read(v);
    check("status_01", v, 16'h0001);

    bus_write(16'h0000);
    dev_frame(11, 1, samp, rts);
    check("bits_00", samp, 11'h600);
    wait_status_bit(15, 1'b0, "idle_00");
    bus_read(v);
    check("status_00", v, 16'h0000);

    // NACK, then cleared by the next write
    bus_write(16'h00FF);
    dev_frame(11, 0, samp, rts);
    wait_status_bit(15, 1'b0, "idle_ff");
    bus_read(v);
    check("status_nack", v, 16'h40FF);
    bus_write(16'h00F4);
    bus_read(v);
    check("nack_cleared_busy", v, 16'h80F4);
    dev_frame(11, 1, samp, rts);
    wait_status_bit(15, 1'b0, "idle_f4");
    bus_read(v);
    check("status_f4", v, 16'h00F4);

    // No device clock: start timeout
    bus_write(16'h0055);
    wait_status_bit(13, 1'b1, "start_to_flag");
    check("start_to_len", ecount - fw, INH + 1 + S);
    check("start_to_lines", {ps2c_oe_o, ps2d_oe_o}, 2'b00);
    wait_status_bit(15, 1'b0, "idle_55");
    bus_read(v);
    check("status_start_to", v, 16'h2055);

    // Device stops after edge 5: frame timeout
    bus_write(16'h003C);
    dev_frame(5, 1, samp, rts);
    wait_status_bit(13, 1'b1, "frame_to_flag");
    check("frame_to_len", ecount - rx[1], F);
    wait_status_bit(15, 1'b0, "idle_3c");
    bus_read(v);
    check("status_frame_to", v, 16'h203C);

    // Write while busy: overrun, frame continues with $ED
    bus_write(16'h00ED);
    bus_write(16'h00AA);
    bus_read(v);
    check("status_overrun_busy", v, 16'h90ED);
    dev_frame(11, 1, samp, rts);
    check("bits_overrun", samp, 11'h7DA);
    wait_status_bit(15, 1'b0, "idle_ovr");
    bus_read(v);
    check("status_overrun_done", v, 16'h10ED);

    // Reset during INHIBIT releases lines at once
    bus_write(16'h0077);
    repeat (5) @(negedge clk);
    check("c_low_before_rst", ps2c_oe_o, 1);
    #3;
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    check("rst_lines", {ps2c_oe_o, ps2d_oe_o}, 2'b00);
    have = 0;
    prev_status = '0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;
    bus_read(v);
    check("status_after_rst", v, 16'h0000);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
